// File: rtl/fft_unload.sv
// fft_unload: drains one FFT frame from the RAM that holds the final stage.
// Reads are throttled so that reads in flight never overrun a 2-entry skid
// buffer. Each bin leaves on a valid/ready stream with its L1 magnitude and
// index. The bench-free peak tracker records the largest non-DC bin.
module fft_unload #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter bit HALF      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fft_done,
    input  logic                        read_sel,
    input  logic [2*BIT_WIDTH-1:0]      r0_rd_data,
    input  logic [2*BIT_WIDTH-1:0]      r1_rd_data,
    output logic [N-1:0]                rd_add,
    output logic                        rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_re,
    output logic signed [BIT_WIDTH-1:0] out_im,
    output logic [BIT_WIDTH:0]          out_mag,
    output logic [N-1:0]                out_idx,
    output logic                        out_last,
    output logic                        busy,
    output logic [N-1:0]                peak_idx,
    output logic [BIT_WIDTH:0]          peak_mag,
    output logic                        peak_valid,
    output logic                        overrun
);

    localparam int          M        = HALF ? (1 << (N - 1)) : (1 << N);
    localparam logic [N-1:0] LAST_ADD = N'(M - 1);
    localparam int          MW       = BIT_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    // |v| widened by one bit so the most negative value needs no saturation
    function automatic logic [MW-1:0] abs_ext(input logic signed [BIT_WIDTH-1:0] v);
        logic [MW-1:0] w;
        w = {v[BIT_WIDTH-1], v};
        return w[MW-1] ? (~w + MW'(1)) : w;
    endfunction

    state_t state, state_nxt;
    logic   done_q;
    logic   sel_q;
    logic   rise, start, finish;
    logic   [N-1:0] cnt;

    logic   vld_p0;
    logic   [N-1:0] idx_p0;

    logic   [2*BIT_WIDTH-1:0]      word_p1;
    logic   signed [BIT_WIDTH-1:0] re_p1, im_p1;
    logic   [MW-1:0]               mag_p1;

    logic   signed [BIT_WIDTH-1:0] buf_re   [2];
    logic   signed [BIT_WIDTH-1:0] buf_im   [2];
    logic   [MW-1:0]               buf_mag  [2];
    logic   [N-1:0]                buf_idx  [2];
    logic                          buf_last [2];
    logic   wr_ptr, rd_ptr;
    logic   [1:0] occ, occ_nxt;
    logic   [2:0] room;
    logic   rd_ok, pop;

    logic   [N-1:0]  peak_idx_q;
    logic   [MW-1:0] peak_mag_q;
    logic   peak_valid_q;
    logic   overrun_q;

    assign rise  = fft_done & ~done_q;
    assign start = rise && (state == S_IDLE);
    assign busy  = (state != S_IDLE);

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_re    = buf_re[rd_ptr];
    assign out_im    = buf_im[rd_ptr];
    assign out_mag   = buf_mag[rd_ptr];
    assign out_idx   = buf_idx[rd_ptr];
    assign out_last  = buf_last[rd_ptr];

    // A read may issue only if the buffer can still absorb it next cycle
    assign room  = {1'b0, occ} + {2'b00, vld_p0};
    assign rd_ok = (room < 3'd2) || (pop && (room == 3'd2));

    assign rd_add     = cnt;
    assign peak_idx   = peak_idx_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign overrun    = overrun_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, read strobe and end-of-frame detection
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_READ;
            end
            S_READ: begin
                rd_en = rd_ok;
                if (rd_ok && (cnt == LAST_ADD)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!vld_p0 && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Start edge detection, RAM select latch, overrun flag and peak pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q       <= 1'b0;
            sel_q        <= 1'b0;
            overrun_q    <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            done_q       <= fft_done;
            peak_valid_q <= finish;
            if (start) begin
                sel_q     <= read_sel;
                overrun_q <= 1'b0;
            end else if (rise && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Read address counter; parks on the final address once issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          cnt <= '0;
        else if (start)                      cnt <= '0;
        else if (rd_en && cnt != LAST_ADD)   cnt <= cnt + N'(1);
    end

    // ---- stage p0: read issued, RAM access in flight ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            idx_p0 <= '0;
        end else begin
            vld_p0 <= rd_en;
            if (rd_en) idx_p0 <= cnt;
        end
    end

    // ---- stage p1: read data landed, split and magnitude ----
    assign word_p1 = sel_q ? r1_rd_data : r0_rd_data;
    assign re_p1   = word_p1[2*BIT_WIDTH-1:BIT_WIDTH];
    assign im_p1   = word_p1[BIT_WIDTH-1:0];
    assign mag_p1  = abs_ext(re_p1) + abs_ext(im_p1);

    always_comb begin
        occ_nxt = occ;
        case ({vld_p0, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Skid buffer: landed data written at wr_ptr, head presented at rd_ptr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_re[i]   <= '0;
                buf_im[i]   <= '0;
                buf_mag[i]  <= '0;
                buf_idx[i]  <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            occ <= occ_nxt;
            if (vld_p0) begin
                buf_re[wr_ptr]   <= re_p1;
                buf_im[wr_ptr]   <= im_p1;
                buf_mag[wr_ptr]  <= mag_p1;
                buf_idx[wr_ptr]  <= idx_p0;
                buf_last[wr_ptr] <= (idx_p0 == LAST_ADD);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    // Peak tracker over accepted non-DC bins; strict compare keeps lowest index on ties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_idx_q <= '0;
            peak_mag_q <= '0;
        end else if (start) begin
            peak_idx_q <= '0;
            peak_mag_q <= '0;
        end else if (pop && (out_idx != '0) && (out_mag > peak_mag_q)) begin
            peak_idx_q <= out_idx;
            peak_mag_q <= out_mag;
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// Scoreboard bench for fft_unload: stimulus queues expected bins and peaks,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fft_unload;

    localparam int BW = 16;
    localparam int NA = 9;
    localparam int M  = 256;

    typedef struct {
        int re;
        int im;
        int mag;
        int idx;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic fft_done = 1'b0, read_sel = 1'b0, out_ready = 1'b1;
    logic [2*BW-1:0] r0_rd_data = '0, r1_rd_data = '0;
    logic [NA-1:0] rd_add, out_idx, peak_idx;
    logic rd_en, out_valid, out_last, busy, peak_valid, overrun;
    logic signed [BW-1:0] out_re, out_im;
    logic [BW:0] out_mag, peak_mag;

    logic fft_done_f = 1'b0;
    logic [2*BW-1:0] f_r0 = '0;
    logic [2*BW-1:0] zero_w = '0;
    logic [NA-1:0] f_add, f_idx, f_pidx;
    logic f_en, f_valid, f_last, f_busy, f_pvalid, f_ovr;
    logic signed [BW-1:0] f_re, f_im;
    logic [BW:0] f_mag, f_pmag;

    logic [2*BW-1:0] ram0 [512];
    logic [2*BW-1:0] ram1 [512];

    exp_t sbq [$];
    int   pk_idx_q [$];
    int   pk_mag_q [$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;
    int f_next = 0;
    bit stall_prev = 1'b0;
    int held_idx, held_mag, held_re;

    fft_unload #(.BIT_WIDTH(BW), .N(NA), .HALF(1'b1)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .read_sel(read_sel),
        .r0_rd_data(r0_rd_data), .r1_rd_data(r1_rd_data),
        .rd_add(rd_add), .rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_mag(out_mag), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .peak_idx(peak_idx), .peak_mag(peak_mag),
        .peak_valid(peak_valid), .overrun(overrun)
    );

    fft_unload #(.BIT_WIDTH(BW), .N(NA), .HALF(1'b0)) u_full (
        .clk(clk), .reset(reset), .fft_done(fft_done_f), .read_sel(1'b0),
        .r0_rd_data(f_r0), .r1_rd_data(zero_w),
        .rd_add(f_add), .rd_en(f_en), .out_valid(f_valid), .out_ready(1'b1),
        .out_re(f_re), .out_im(f_im), .out_mag(f_mag), .out_idx(f_idx),
        .out_last(f_last), .busy(f_busy), .peak_idx(f_pidx), .peak_mag(f_pmag),
        .peak_valid(f_pvalid), .overrun(f_ovr)
    );

    // synchronous RAM models, one cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            r0_rd_data <= ram0[rd_add];
            r1_rd_data <= ram1[rd_add];
        end
        if (f_en) f_r0 <= ram0[f_add];
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mag_of(input logic [2*BW-1:0] w);
        return iabs(int'($signed(w[31:16]))) + iabs(int'($signed(w[15:0])));
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < 512; a++) ram0[a] = {16'(a), 16'(-a)};
    endtask

    task automatic push_frame(input bit sel);
        exp_t e;
        logic [2*BW-1:0] w;
        int best_i, best_m;
        best_i = 0;
        best_m = 0;
        for (int a = 0; a < M; a++) begin
            w      = sel ? ram1[a] : ram0[a];
            e.re   = int'($signed(w[31:16]));
            e.im   = int'($signed(w[15:0]));
            e.mag  = iabs(e.re) + iabs(e.im);
            e.idx  = a;
            e.last = (a == M - 1) ? 1 : 0;
            sbq.push_back(e);
            if (a >= 1 && e.mag > best_m) begin
                best_m = e.mag;
                best_i = a;
            end
        end
        pk_idx_q.push_back(best_i);
        pk_mag_q.push_back(best_m);
    endtask

    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            tick();
            i++;
        end
        check({nm, "_drain_end"}, busy, 0);
        tick();
        tick();
        check({nm, "_bins_left"}, sbq.size(), 0);
        check({nm, "_peak_pending"}, pk_idx_q.size(), 0);
    endtask

    task automatic wait_bin(input int idx);
        int i;
        i = 0;
        while (!(out_valid && out_idx == NA'(idx)) && i < 1000) begin
            tick();
            i++;
        end
        check("wait_bin_reached", out_idx, idx);
    endtask

    // monitor: main stream against scoreboard, stall stability, peak pulse
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (stall_prev) begin
                check("stall_idx", out_idx, held_idx);
                check("stall_mag", out_mag, held_mag);
                check("stall_re", out_re, held_re);
            end
            if (out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_bin", out_idx, -1);
                end else begin
                    mon_e = sbq.pop_front();
                    check("bin_idx", out_idx, mon_e.idx);
                    check("bin_re", out_re, mon_e.re);
                    check("bin_im", out_im, mon_e.im);
                    check("bin_mag", out_mag, mon_e.mag);
                    check("bin_last", out_last, mon_e.last);
                end
            end
        end
        stall_prev = reset && out_valid && !out_ready;
        held_idx   = out_idx;
        held_mag   = out_mag;
        held_re    = out_re;
        if (peak_valid) begin
            if (pk_idx_q.size() == 0) begin
                check("unexpected_peak_valid", 1, 0);
            end else begin
                check("peak_idx", peak_idx, pk_idx_q.pop_front());
                check("peak_mag", peak_mag, pk_mag_q.pop_front());
            end
        end
    end

    // monitor: full-frame instance, ramp data in RAM0
    always @(negedge clk) begin
        if (reset && f_valid) begin
            check("full_idx", f_idx, f_next);
            check("full_mag", f_mag, mag_of(ram0[f_next]));
            check("full_last", f_last, (f_next == 511) ? 1 : 0);
            f_next++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        int i;
        fill_ramp();
        for (int a = 0; a < 512; a++) ram1[a] = '0;

        // reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_rd_add", rd_add, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: RAM0 ramp, latency and full throughput
        read_sel = 1'b0;
        push_frame(1'b0);
        pulse();
        check("t1_rd_en_first", rd_en, 1);
        check("t1_rd_add_first", rd_add, 0);
        check("t1_busy", busy, 1);
        check("t1_valid_early0", out_valid, 0);
        tick();
        check("t1_valid_early1", out_valid, 0);
        tick();
        check("t1_first_valid", out_valid, 1);
        check("t1_first_idx", out_idx, 0);
        nvalid = 0;
        for (int c = 0; c < M; c++) begin
            if (out_valid) nvalid++;
            tick();
        end
        check("t1_no_bubbles", nvalid, M);
        wait_done("t1");
        check("t1_peak_idx_final", peak_idx, 255);
        check("t1_peak_mag_final", peak_mag, 510);

        // 2: RAM1 select, most negative components
        ram1[5] = 32'h8000_8000;
        read_sel = 1'b1;
        push_frame(1'b1);
        pulse();
        read_sel = 1'b0;
        wait_done("t2");
        check("t2_peak_idx_final", peak_idx, 5);
        check("t2_peak_mag_final", peak_mag, 65536);

        // 3: backpressure with a 10-cycle stall
        push_frame(1'b0);
        pulse();
        for (int c = 0; c < 3000 && busy; c++) begin
            if (c >= 100 && c < 110) out_ready = 1'b0;
            else                     out_ready = (c % 3) != 0;
            if (c == 106) begin
                check("t3_stall_rd_en", rd_en, 0);
                check("t3_stall_valid", out_valid, 1);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_done("t3");

        // 4: DC excluded, ties keep lowest index
        for (int a = 0; a < 512; a++) ram0[a] = {16'(a % 100), 16'd0};
        ram0[0] = {16'd1000, 16'd0};
        ram0[7] = {16'd100, 16'(-200)};
        ram0[9] = {16'(-300), 16'd0};
        push_frame(1'b0);
        pulse();
        wait_done("t4");
        check("t4_peak_idx_final", peak_idx, 7);
        check("t4_peak_mag_final", peak_mag, 300);

        // 5: overrun, then cleared by a clean start
        fill_ramp();
        push_frame(1'b0);
        pulse();
        wait_bin(100);
        pulse();
        check("t5_overrun_set", overrun, 1);
        wait_done("t5a");
        check("t5_overrun_sticky", overrun, 1);
        push_frame(1'b0);
        pulse();
        check("t5_overrun_clear", overrun, 0);
        wait_done("t5b");

        // 6: async reset mid-frame, then clean frames on both instances
        push_frame(1'b0);
        pulse();
        wait_bin(50);
        reset = 1'b0;
        sbq.delete();
        pk_idx_q.delete();
        pk_mag_q.delete();
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_idx", out_idx, 0);
        check("t6_rst_mag", out_mag, 0);
        check("t6_rst_peak_mag", peak_mag, 0);
        check("t6_rst_rd_add", rd_add, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        push_frame(1'b0);
        pulse();
        wait_done("t6");

        fft_done_f = 1'b1;
        tick();
        fft_done_f = 1'b0;
        i = 0;
        while (f_busy && i < 2000) begin
            tick();
            i++;
        end
        check("full_drain_end", f_busy, 0);
        tick();
        check("full_bin_count", f_next, 512);
        check("full_peak_idx", f_pidx, 511);
        check("full_peak_mag", f_pmag, 1022);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
